// File: rtl/data_ram_ws.sv
// Word-addressed data RAM with a cs/ready handshake and a fixed number of wait states.
// Optional even-parity protection is built when DATA_RAM_PARITY_EN is defined.
module data_ram_ws #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              read_not_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              ready,
    output logic              busy,
    output logic              parity_err
);

`ifdef DATA_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS4 = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        wait_cnt;
    logic              rnw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              mem_go;
    logic              eff_rnw;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic              in_range;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    logic [MEM_W-1:0]  mem [0:DEPTH-1];

    assign accept = (state == S_IDLE) && cs;

    // With zero wait states the access happens on the accepting edge, so the
    // raw inputs are used instead of the (not yet loaded) latched copies.
    assign eff_rnw   = accept ? read_not_write : rnw_q;
    assign eff_addr  = accept ? address        : addr_q;
    assign eff_wdata = accept ? write_data     : wdata_q;

    assign mem_go = ((state == S_WAIT) && (wait_cnt == 4'd1)) ||
                    (accept && (WAIT_STATES == 0));

    assign in_range = ({1'b0, eff_addr} < DEPTH_L);

`ifdef DATA_RAM_PARITY_EN
    assign wr_word = {^eff_wdata, eff_wdata};
`else
    assign wr_word = eff_wdata;
`endif

    assign rd_word = in_range ? mem[eff_addr[IDX_W-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cs) begin
                    next_state = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            S_WAIT: busy = 1'b1;
            S_DONE: begin
                busy  = 1'b1;
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rnw_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            wait_cnt <= WS4;
            rnw_q    <= read_not_write;
            addr_q   <= address;
            wdata_q  <= write_data;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // read_data only moves on a completing read; out-of-range reads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= '0;
        end else if (mem_go && eff_rnw) begin
            read_data <= rd_word[DATA_W-1:0];
        end
    end

`ifdef DATA_RAM_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= mem_go && eff_rnw && in_range && (^rd_word);
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // The array has no reset; a write aborted by reset never sees mem_go.
    always_ff @(posedge clk) begin
        if (mem_go && !eff_rnw && in_range) begin
            mem[eff_addr[IDX_W-1:0]] <= wr_word;
        end
    end

endmodule
